// File: rtl/dense_layer_mac_if.sv
// Bundle of the layer's start/result handshake and its external weight-ROM port.
// The master is the upstream/ROM side; the slave is the layer itself.
interface dense_layer_mac_if #(
   parameter int NEURON_NB = 10,
   parameter int INPUT_NB  = 32,
   parameter int WIDTH     = 8
);
   localparam int AW = (NEURON_NB * INPUT_NB > 1) ? $clog2(NEURON_NB * INPUT_NB) : 1;

   logic                      enable;
   logic signed [WIDTH-1:0]   in_data  [0:INPUT_NB-1];
   logic signed [2*WIDTH-1:0] bias     [0:NEURON_NB-1];
   logic [AW-1:0]             weight_addr;
   logic signed [WIDTH-1:0]   weight_data;
   logic signed [2*WIDTH-1:0] out_data [0:NEURON_NB-1];
   logic                      busy;
   logic                      layer_done;

   modport master (
      output enable, in_data, bias, weight_data,
      input  weight_addr, out_data, busy, layer_done
   );

   modport slave (
      input  enable, in_data, bias, weight_data,
      output weight_addr, out_data, busy, layer_done
   );
endinterface

// File: rtl/dense_layer_mac.sv
// Time-multiplexed fully connected layer: one multiplier, one neuron per INPUT_NB+1 cycles,
// weights streamed from a synchronous ROM with one cycle of read latency.
module dense_layer_mac #(
   parameter int NEURON_NB = 10,
   parameter int INPUT_NB  = 32,
   parameter int WIDTH     = 8,
   parameter int RELU      = 0
) (
   input logic clk,
   input logic reset,
   dense_layer_mac_if.slave lyr
);
   localparam int OW    = 2 * WIDTH;
   localparam int ACC_W = OW + $clog2(INPUT_NB + 1) + 1;
   localparam int CW    = $clog2(INPUT_NB + 1);
   localparam int IW    = (INPUT_NB > 1) ? $clog2(INPUT_NB) : 1;
   localparam int NW    = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
   localparam int AW    = (NEURON_NB * INPUT_NB > 1) ? $clog2(NEURON_NB * INPUT_NB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]              r_state;
   logic [CW-1:0]           r_c;
   logic [NW-1:0]           r_n;
   logic [AW-1:0]           r_addr;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [OW-1:0]    r_out [0:NEURON_NB-1];
   logic                    r_busy;
   logic                    r_done;

   logic [IW-1:0]           w_idx;
   logic signed [OW-1:0]    w_x;
   logic signed [OW-1:0]    w_w;
   logic signed [OW-1:0]    w_prod;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_bias_ext;
   logic signed [OW-1:0]    w_result;

   function automatic logic signed [OW-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v[ACC_W-1:OW-1] == {(ACC_W-OW+1){v[ACC_W-1]}})
         return v[OW-1:0];
      else if (v[ACC_W-1])
         return {1'b1, {(OW-1){1'b0}}};
      else
         return {1'b0, {(OW-1){1'b1}}};
   endfunction

   function automatic logic signed [OW-1:0] relu(input logic signed [OW-1:0] v);
      if (RELU != 0 && v[OW-1])
         return '0;
      return v;
   endfunction

   // Phase c consumes the ROM word addressed during phase c-1, paired with in_data[c-1].
   assign w_idx      = (r_c == '0) ? '0 : IW'(r_c - CW'(1));
   assign w_x        = $signed({{WIDTH{lyr.in_data[w_idx][WIDTH-1]}}, lyr.in_data[w_idx]});
   assign w_w        = $signed({{WIDTH{lyr.weight_data[WIDTH-1]}}, lyr.weight_data});
   assign w_prod     = w_x * w_w;
   assign w_sum      = r_acc + $signed({{(ACC_W-OW){w_prod[OW-1]}}, w_prod});
   assign w_bias_ext = $signed({{(ACC_W-OW){lyr.bias[r_n][OW-1]}}, lyr.bias[r_n]});
   assign w_result   = relu(sat(w_sum));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_c     <= '0;
         r_n     <= '0;
         r_addr  <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < NEURON_NB; i++)
            r_out[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (lyr.enable) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_c     <= '0;
                  r_n     <= '0;
                  r_addr  <= '0;
               end
            end
            S_RUN: begin
               if (r_c == CW'(INPUT_NB)) begin
                  r_out[r_n] <= w_result;
                  r_c        <= '0;
                  if (r_n == NW'(NEURON_NB - 1)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_n     <= '0;
                     r_addr  <= '0;
                  end else begin
                     r_n    <= r_n + NW'(1);
                     r_addr <= r_addr + AW'(1);
                  end
               end else begin
                  r_acc <= (r_c == '0) ? w_bias_ext : w_sum;
                  r_c   <= r_c + CW'(1);
                  // Address stops at the neuron's last weight while the drain phase consumes it.
                  if (r_c < CW'(INPUT_NB - 1))
                     r_addr <= r_addr + AW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign lyr.weight_addr = r_addr;
   assign lyr.out_data    = r_out;
   assign lyr.busy        = r_busy;
   assign lyr.layer_done  = r_done;
endmodule

// File: doc/dense_layer_mac.md
# dense_layer_mac

Time-multiplexed fully connected layer that computes NEURON_NB signed outputs from INPUT_NB signed inputs with a single multiplier. Weights are read from an external synchronous ROM, one per cycle. The block sits directly upstream of the max-selection stage. Its `out_data` array and `layer_done` connect to that stage's `in_data` and `enable`; the max-selection stage starts scanning only once every output is final and stable.

## Interface
- `NEURON_NB`, 10: number of neurons (outputs).
- `INPUT_NB`, 32: number of inputs per neuron.
- `WIDTH`, 8: input and weight width. Outputs are 2*WIDTH.
- `RELU`, 0: 1 clamps negative results to 0 after saturation. 0 passes signed results unchanged (used for the last layer).
- `clk`  in  1  clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  start request. Sampled in IDLE and DONE only.
- `in_data`  in  signed WIDTH x [0:INPUT_NB-1]  layer inputs. Upstream holds them stable from the start edge until `layer_done` rises.
- `bias`  in  signed 2*WIDTH x [0:NEURON_NB-1]  per-neuron bias. Held stable like `in_data`.
- `weight_addr`  out  $clog2(NEURON_NB*INPUT_NB)  ROM address, equal to n*INPUT_NB + j.
- `weight_data`  in  signed WIDTH  ROM data. Valid one cycle after the matching `weight_addr`.
- `out_data`  out  signed 2*WIDTH x [0:NEURON_NB-1]  registered neuron results.
- `busy`  out  1  high while computing.
- `layer_done`  out  1  level signal. High when all outputs are final.

## Operation
- FSM states:
  - IDLE: wait for a start request.
  - RUN: compute neurons one after another.
  - DONE: results final.
- Transitions:
  - IDLE -> RUN on `enable`=1.
  - RUN -> DONE after the last neuron is stored.
  - DONE -> RUN on `enable`=1 (restart).
  - DONE stays in DONE while `enable`=0.
- `enable` is ignored in RUN.
- Per neuron n, the block spends INPUT_NB+1 cycles, with phase counter c running 0..INPUT_NB:
  - c=0: the accumulator loads `bias[n]`, sign-extended. `weight_addr` = n*INPUT_NB.
  - c=1..INPUT_NB-1: `weight_addr` = n*INPUT_NB+c. The accumulator adds `in_data[c-1]*weight_data`.
  - c=INPUT_NB (drain): `weight_addr` holds its previous value. The final sum is the accumulator plus `in_data[INPUT_NB-1]*weight_data`. That sum is saturated, ReLU'd if RELU=1, and written to `out_data[n]` on this edge. The counter then moves to the next neuron at c=0.
- Arithmetic widths:
  - Product: 2*WIDTH bits, signed.
  - Accumulator: 2*WIDTH + $clog2(INPUT_NB+1) + 1 bits, signed. It never overflows internally.
- Saturation: results above 2^(2*WIDTH-1)-1 become that value. Results below -2^(2*WIDTH-1) become that value.
- `out_data` entries not yet computed keep their previous value.
- On a restart from DONE:
  - All `out_data` entries keep their old values until each is overwritten in turn.
  - `layer_done` falls on the start edge.
- `reset` has priority over everything, including an active `enable`. On reset:
  - the FSM goes to IDLE;
  - all `out_data` entries go to 0;
  - `layer_done` = 0, `busy` = 0, `weight_addr` = 0;
  - the counters and accumulator are cleared.

## Timing
- Reset values: `out_data` all 0, `layer_done` 0, `busy` 0, `weight_addr` 0.
- The start edge is the edge at which `enable`=1 is sampled in IDLE or DONE. `busy` is 1 from that edge.
- `out_data[n]` updates at edge (n+1)*(INPUT_NB+1) after the start edge.
- `layer_done` rises and `busy` falls together, at edge NEURON_NB*(INPUT_NB+1) after the start edge, the same edge as the last store. With the defaults this is 330 cycles.
- `layer_done` stays high until reset or a restart.
- The ROM must have exactly one cycle of read latency. The block issues no stalls and accepts no back-pressure.
- Reset asserted mid-RUN aborts the computation. The next cycle shows the reset values. A later start recomputes from scratch.

## Test plan
Tests 1–4 and 6 use WIDTH=8, INPUT_NB=4, NEURON_NB=3. Test 5 uses the default parameters.

1. Basic sum: all `in_data`=1, all weights=1, `bias`=0, `enable` pulsed once. Required: `out_data` = {4,4,4}. `out_data[0]` updates at edge 5. `layer_done` rises and `busy` falls at edge 15.
2. Saturation:
   - `in_data`=127, weights=127 -> every output = 32767 (true sum 64516).
   - Weights=-128 -> every output = -32768 (true sum -65024).
3. Bias and ReLU: `in_data`=0, `bias`={-150,-50,50}.
   - RELU=0 -> `out_data` = {-150,-50,50}.
   - RELU=1 -> `out_data` = {0,0,50}.
4. Address sequence: `weight_addr` per cycle after the start edge = 0,1,2,3,3,4,5,6,7,7,8,9,10,11,11. Each `weight_data` value is consumed exactly one cycle after its address is issued.
5. Reset mid-run:
   - Assert `reset` at cycle 7 of a default-parameter run. The next cycle shows `out_data` all 0, `layer_done`=0, `busy`=0, FSM in IDLE.
   - A fresh start then gives results matching a golden model.
6. Handshake:
   - `enable` held high through RUN does not restart the run; `layer_done` still rises at edge 15.
   - `enable`=1 while in DONE drops `layer_done` on that edge. New results appear neuron by neuron, and `layer_done` rises again 15 edges later.
